// File: rtl/opb_master_pkg.sv
// -----------------------------------------------------------------------------
// opb_master_pkg
// Shared types and constants for the OPB user master:
//   - state_t    : master FSM states
//   - ST_*       : response status codes returned on rsp_status
//   - OPB_*WIDTH : OPB bus widths
// -----------------------------------------------------------------------------
package opb_master_pkg;

   localparam int OPB_AWIDTH  = 32;
   localparam int OPB_DWIDTH  = 32;
   localparam int OPB_BEWIDTH = OPB_DWIDTH / 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      XFER    = 3'd2,
      BACKOFF = 3'd3,
      RESP    = 3'd4
   } state_t;

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_ERR   = 2'b01;
   localparam logic [1:0] ST_TOUT  = 2'b10;
   localparam logic [1:0] ST_RETRY = 2'b11;

endpackage

// File: rtl/opb_master_watchdog.sv
// -----------------------------------------------------------------------------
// opb_master_watchdog
// Cycle counter that bounds how long a selected OPB transfer may stay open.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   clr    : force the count to zero (has priority over en)
//   en     : count up by one per cycle
//   expire : count has reached C_TIMEOUT-1; the count holds there
// -----------------------------------------------------------------------------
module opb_master_watchdog #(
   parameter int C_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int            CW    = $clog2(C_TIMEOUT);
   localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT - 1);

   logic [CW-1:0] count_r;

   // Count register; saturates at LIMIT so it can never wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= {CW{1'b0}};
      end else if (clr) begin
         count_r <= {CW{1'b0}};
      end else if (en && (count_r != LIMIT)) begin
         count_r <= count_r + 1'b1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = (count_r == LIMIT);

endmodule

// File: rtl/opb_user_master.sv
// -----------------------------------------------------------------------------
// opb_user_master
// Single-beat OPB bus master driven by a valid/ready command port. Each accepted
// command becomes one arbitrated OPB transfer (with bounded retries) and returns
// exactly one response.
// Ports:
//   OPB_Clk, OPB_Rst_n          : clock, synchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake (ready only in IDLE)
//   cmd_rnw/addr/be/wdata       : command fields, latched on accept
//   rsp_valid/rsp_ready         : response handshake
//   rsp_rdata/rsp_status        : read data (0 unless OK read), status code
//   M_request/M_select          : arbiter request, transfer in progress
//   M_ABus/M_BE/M_DBus/M_RNW    : OPB master buses, zero when not selected
//   M_seqAddr                   : tied low (no sequential bursts)
//   OPB_MGrant                  : arbiter grant (looked at only in REQ)
//   OPB_DBus                    : slave read data
//   OPB_xferAck/errAck/retry/timeout : transfer terminations (only in XFER)
// -----------------------------------------------------------------------------
module opb_user_master
   import opb_master_pkg::*;
#(
   parameter int C_OPB_AWIDTH = OPB_AWIDTH,
   parameter int C_OPB_DWIDTH = OPB_DWIDTH,
   parameter int C_MAX_RETRY  = 3,
   parameter int C_TIMEOUT    = 64
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_rnw,
   input  logic [C_OPB_AWIDTH-1:0] cmd_addr,
   input  logic [OPB_BEWIDTH-1:0]  cmd_be,
   input  logic [C_OPB_DWIDTH-1:0] cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [C_OPB_DWIDTH-1:0] rsp_rdata,
   output logic [1:0]              rsp_status,
   output logic                    M_request,
   output logic                    M_select,
   output logic [0:C_OPB_AWIDTH-1] M_ABus,
   output logic [0:OPB_BEWIDTH-1]  M_BE,
   output logic [0:C_OPB_DWIDTH-1] M_DBus,
   output logic                    M_RNW,
   output logic                    M_seqAddr,
   input  logic                    OPB_MGrant,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_xferAck,
   input  logic                    OPB_errAck,
   input  logic                    OPB_retry,
   input  logic                    OPB_timeout
);

   localparam logic [3:0] MAX_RETRY = 4'(C_MAX_RETRY);

   state_t state_r;
   state_t state_s;

   // latched command
   logic                    cmd_rnw_r;
   logic [C_OPB_AWIDTH-1:0] cmd_addr_r;
   logic [OPB_BEWIDTH-1:0]  cmd_be_r;
   logic [C_OPB_DWIDTH-1:0] cmd_wdata_r;
   logic [3:0]              retry_cnt_r;

   // next-state decode results
   logic       accept_s;
   logic       retry_inc_s;
   logic       capture_s;
   logic [1:0] term_status_s;
   logic       wd_expire_s;

   // next values of the registered outputs
   logic                    cmd_ready_s,  cmd_ready_r;
   logic                    m_request_s,  m_request_r;
   logic                    m_select_s,   m_select_r;
   logic [C_OPB_AWIDTH-1:0] m_abus_s,     m_abus_r;
   logic [OPB_BEWIDTH-1:0]  m_be_s,       m_be_r;
   logic [C_OPB_DWIDTH-1:0] m_dbus_s,     m_dbus_r;
   logic                    m_rnw_s,      m_rnw_r;
   logic                    rsp_valid_s,  rsp_valid_r;
   logic [C_OPB_DWIDTH-1:0] rsp_rdata_s,  rsp_rdata_r;
   logic [1:0]              rsp_status_s, rsp_status_r;

   // Watchdog is cleared every cycle outside XFER, so it restarts at 0 on each
   // entry (including re-entry after a retry back-off).
   opb_master_watchdog #(
      .C_TIMEOUT (C_TIMEOUT)
   ) u_watchdog (
      .clk    (OPB_Clk),
      .rst_n  (OPB_Rst_n),
      .clr    (state_r != XFER),
      .en     (state_r == XFER),
      .expire (wd_expire_s)
   );

   // State register.
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode, including termination priority in XFER.
   always_comb begin
      state_s       = state_r;
      accept_s      = 1'b0;
      retry_inc_s   = 1'b0;
      capture_s     = 1'b0;
      term_status_s = ST_OK;
      case (state_r)
         IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               accept_s = 1'b1;
               state_s  = REQ;
            end else begin
               state_s  = IDLE;
            end
         end
         REQ: begin
            if (OPB_MGrant) begin
               state_s = XFER;
            end else begin
               state_s = REQ;
            end
         end
         XFER: begin
            if (OPB_retry) begin
               if (retry_cnt_r < MAX_RETRY) begin
                  retry_inc_s = 1'b1;
                  state_s     = BACKOFF;
               end else begin
                  term_status_s = ST_RETRY;
                  state_s       = RESP;
               end
            end else if (OPB_errAck) begin
               term_status_s = ST_ERR;
               state_s       = RESP;
            end else if (OPB_xferAck) begin
               term_status_s = ST_OK;
               capture_s     = cmd_rnw_r;
               state_s       = RESP;
            end else if (OPB_timeout || wd_expire_s) begin
               term_status_s = ST_TOUT;
               state_s       = RESP;
            end else begin
               state_s = XFER;
            end
         end
         BACKOFF: begin
            state_s = REQ;
         end
         RESP: begin
            if (rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output is a plain register.
   always_comb begin
      cmd_ready_s = (state_s == IDLE);
      m_request_s = (state_s == REQ);
      m_select_s  = (state_s == XFER);
      rsp_valid_s = (state_s == RESP);

      // wired-OR bus: drive nothing unless selected, and no write data on reads
      if (state_s == XFER) begin
         m_abus_s = cmd_addr_r;
         m_be_s   = cmd_be_r;
         m_rnw_s  = cmd_rnw_r;
         if (cmd_rnw_r) begin
            m_dbus_s = {C_OPB_DWIDTH{1'b0}};
         end else begin
            m_dbus_s = cmd_wdata_r;
         end
      end else begin
         m_abus_s = {C_OPB_AWIDTH{1'b0}};
         m_be_s   = {OPB_BEWIDTH{1'b0}};
         m_rnw_s  = 1'b0;
         m_dbus_s = {C_OPB_DWIDTH{1'b0}};
      end

      // response loads on the terminating cycle and is held until consumed
      if ((state_r == XFER) && (state_s == RESP)) begin
         rsp_status_s = term_status_s;
         if (capture_s) begin
            rsp_rdata_s = OPB_DBus;
         end else begin
            rsp_rdata_s = {C_OPB_DWIDTH{1'b0}};
         end
      end else if (state_s == RESP) begin
         rsp_status_s = rsp_status_r;
         rsp_rdata_s  = rsp_rdata_r;
      end else begin
         rsp_status_s = ST_OK;
         rsp_rdata_s  = {C_OPB_DWIDTH{1'b0}};
      end
   end

   // Output registers.
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         cmd_ready_r  <= 1'b0;
         m_request_r  <= 1'b0;
         m_select_r   <= 1'b0;
         m_abus_r     <= {C_OPB_AWIDTH{1'b0}};
         m_be_r       <= {OPB_BEWIDTH{1'b0}};
         m_dbus_r     <= {C_OPB_DWIDTH{1'b0}};
         m_rnw_r      <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_rdata_r  <= {C_OPB_DWIDTH{1'b0}};
         rsp_status_r <= ST_OK;
      end else begin
         cmd_ready_r  <= cmd_ready_s;
         m_request_r  <= m_request_s;
         m_select_r   <= m_select_s;
         m_abus_r     <= m_abus_s;
         m_be_r       <= m_be_s;
         m_dbus_r     <= m_dbus_s;
         m_rnw_r      <= m_rnw_s;
         rsp_valid_r  <= rsp_valid_s;
         rsp_rdata_r  <= rsp_rdata_s;
         rsp_status_r <= rsp_status_s;
      end
   end

   // Command latch; a reset discards any command in flight.
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         cmd_rnw_r   <= 1'b0;
         cmd_addr_r  <= {C_OPB_AWIDTH{1'b0}};
         cmd_be_r    <= {OPB_BEWIDTH{1'b0}};
         cmd_wdata_r <= {C_OPB_DWIDTH{1'b0}};
      end else if (accept_s) begin
         cmd_rnw_r   <= cmd_rnw;
         cmd_addr_r  <= cmd_addr;
         cmd_be_r    <= cmd_be;
         cmd_wdata_r <= cmd_wdata;
      end else begin
         cmd_rnw_r   <= cmd_rnw_r;
         cmd_addr_r  <= cmd_addr_r;
         cmd_be_r    <= cmd_be_r;
         cmd_wdata_r <= cmd_wdata_r;
      end
   end

   // Retry counter, per command.
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         retry_cnt_r <= 4'd0;
      end else if (accept_s) begin
         retry_cnt_r <= 4'd0;
      end else if (retry_inc_s) begin
         retry_cnt_r <= retry_cnt_r + 4'd1;
      end else begin
         retry_cnt_r <= retry_cnt_r;
      end
   end

   // Array ports are declared MSB-first ([0:N]); plain assignment maps
   // cmd_addr[31-i] onto M_ABus[i], and likewise for BE and data.
   assign cmd_ready  = cmd_ready_r;
   assign M_request  = m_request_r;
   assign M_select   = m_select_r;
   assign M_ABus     = m_abus_r;
   assign M_BE       = m_be_r;
   assign M_DBus     = m_dbus_r;
   assign M_RNW      = m_rnw_r;
   assign M_seqAddr  = 1'b0;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_rdata  = rsp_rdata_r;
   assign rsp_status = rsp_status_r;

endmodule

// File: tb/tb_opb_user_master.sv
// -----------------------------------------------------------------------------
// tb_opb_user_master
// Directed bench for opb_user_master. A cycle-level arbiter/slave model inside
// run_cmd answers each command; all expected values are hand-computed.
// Inputs change and outputs are observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_opb_user_master;
   import opb_master_pkg::*;

   logic        clk = 1'b0;
   logic        OPB_Rst_n;
   logic        cmd_valid, cmd_ready, cmd_rnw;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_be;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        M_request, M_select, M_RNW, M_seqAddr;
   logic [0:31] M_ABus, M_DBus;
   logic [0:3]  M_BE;
   logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout;
   logic [0:31] OPB_DBus;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   opb_user_master #(
      .C_OPB_AWIDTH (32),
      .C_OPB_DWIDTH (32),
      .C_MAX_RETRY  (3),
      .C_TIMEOUT    (64)
   ) dut (
      .OPB_Clk     (clk),
      .OPB_Rst_n   (OPB_Rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_rnw     (cmd_rnw),
      .cmd_addr    (cmd_addr),
      .cmd_be      (cmd_be),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_status  (rsp_status),
      .M_request   (M_request),
      .M_select    (M_select),
      .M_ABus      (M_ABus),
      .M_BE        (M_BE),
      .M_DBus      (M_DBus),
      .M_RNW       (M_RNW),
      .M_seqAddr   (M_seqAddr),
      .OPB_MGrant  (OPB_MGrant),
      .OPB_DBus    (OPB_DBus),
      .OPB_xferAck (OPB_xferAck),
      .OPB_errAck  (OPB_errAck),
      .OPB_retry   (OPB_retry),
      .OPB_timeout (OPB_timeout)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic quiet_bus();
      OPB_MGrant  = 1'b0;
      OPB_xferAck = 1'b0;
      OPB_errAck  = 1'b0;
      OPB_retry   = 1'b0;
      OPB_timeout = 1'b0;
      OPB_DBus    = 32'h0;
   endtask

   // term: 0 xferAck, 1 errAck+xferAck, 2 silent slave, 3 OPB_timeout.
   // The first nretry selects are answered with OPB_retry instead.
   // gdly: request cycles before the grant cycle. adly: select cycle that terminates.
   // exp_lat > 0 checks accept-to-rsp_valid latency; hold keeps rsp_ready low
   // that many cycles with cmd_valid high. Called and returns on a falling edge.
   task automatic run_cmd(input string tag, input logic rnw, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input int gdly, input int adly, input int nretry, input int term,
                          input logic [31:0] rdv, input logic [1:0] exp_status,
                          input logic [31:0] exp_rdata, input int exp_selects,
                          input int exp_sel_len, input int exp_lat, input int hold);
      int   req_cnt = 0, sel_cnt = 0, selects = 0, last_len = 0, acc_cyc = 0, rsp_cyc = 0;
      bit   will_acc = 1'b0, accepted = 1'b0, prev_sel = 1'b0, expect_req = 1'b0;
      bit   bus_bad = 1'b0, done = 1'b0, hold_bad = 1'b0;
      logic [31:0] keep_rdata;
      logic [1:0]  keep_status;

      cmd_valid = 1'b1;
      cmd_rnw   = rnw;
      cmd_addr  = addr;
      cmd_be    = be;
      cmd_wdata = wdata;
      rsp_ready = 1'b0;

      for (int cyc = 0; cyc < 500 && !done; cyc++) begin
         quiet_bus();
         if (will_acc) begin
            accepted  = 1'b1;
            will_acc  = 1'b0;
            cmd_valid = 1'b0;
         end else if (!accepted && cmd_valid && cmd_ready) begin
            will_acc = 1'b1;
            acc_cyc  = cyc;
         end

         if (!M_select && (M_ABus != 32'h0 || M_BE != 4'h0 || M_DBus != 32'h0 || M_RNW))
            bus_bad = 1'b1;
         if (M_select && M_RNW && M_DBus != 32'h0)
            bus_bad = 1'b1;

         if (expect_req) begin
            chk({tag, " rereq"}, M_request, 1'b1);
            expect_req = 1'b0;
         end

         if (M_request) begin
            req_cnt++;
            if (req_cnt > gdly) OPB_MGrant = 1'b1;
         end else begin
            req_cnt = 0;
         end

         if (M_select) begin
            sel_cnt++;
            if (sel_cnt == 1) begin
               chk({tag, " abus"}, M_ABus, addr);
               chk({tag, " be"}, M_BE, be);
               chk({tag, " rnw"}, M_RNW, rnw);
               chk({tag, " dbus"}, M_DBus, rnw ? 32'h0 : wdata);
               chk({tag, " req drop"}, M_request, 1'b0);
            end
            if (sel_cnt == adly) begin
               if (selects < nretry) begin
                  OPB_retry = 1'b1;
               end else begin
                  case (term)
                     0: begin OPB_xferAck = 1'b1; OPB_DBus = rdv; end
                     1: begin OPB_errAck = 1'b1; OPB_xferAck = 1'b1; OPB_DBus = rdv; end
                     3: OPB_timeout = 1'b1;
                     default: ;
                  endcase
               end
            end
         end else if (prev_sel) begin
            selects++;
            last_len = sel_cnt;
            sel_cnt  = 0;
            if (!rsp_valid) begin
               chk({tag, " backoff"}, {M_request, M_select}, 2'b00);
               expect_req = 1'b1;
            end
         end
         prev_sel = M_select;

         if (rsp_valid) begin
            rsp_cyc = cyc;
            done    = 1'b1;
         end else begin
            @(negedge clk);
         end
      end

      chk({tag, " rsp seen"}, done, 1'b1);
      chk({tag, " status"}, rsp_status, exp_status);
      chk({tag, " rdata"}, rsp_rdata, exp_rdata);
      chk({tag, " selects"}, selects, exp_selects);
      chk({tag, " sel len"}, last_len, exp_sel_len);
      chk({tag, " hygiene"}, bus_bad, 1'b0);
      if (exp_lat > 0) chk({tag, " latency"}, rsp_cyc - acc_cyc, exp_lat);

      keep_rdata  = rsp_rdata;
      keep_status = rsp_status;
      if (hold > 0) begin
         cmd_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (cmd_ready || M_request || M_select || !rsp_valid ||
                rsp_rdata !== keep_rdata || rsp_status !== keep_status)
               hold_bad = 1'b1;
         end
         chk({tag, " hold stable"}, hold_bad, 1'b0);
      end

      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, " rsp drop"}, rsp_valid, 1'b0);
      chk({tag, " ready back"}, cmd_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit got_sel = 1'b0;
      bit late_rsp = 1'b0;

      OPB_Rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_rnw   = 1'b0;
      cmd_addr  = 32'h0;
      cmd_be    = 4'h0;
      cmd_wdata = 32'h0;
      rsp_ready = 1'b0;
      quiet_bus();
      repeat (3) @(negedge clk);

      chk("reset ctrl", {cmd_ready, rsp_valid, M_request, M_select, M_RNW, M_seqAddr, M_BE}, 10'h0);
      chk("reset abus", M_ABus, 32'h0);
      chk("reset dbus", M_DBus, 32'h0);
      chk("reset rsp", {rsp_status, rsp_rdata}, 34'h0);

      OPB_Rst_n = 1'b1;
      @(negedge clk);
      chk("idle ready", cmd_ready, 1'b1);

      //      tag       rnw   addr          be       wdata         gd ad nr tm rdv            status    rdata          sel len lat hold
      run_cmd("wr",     1'b0, 32'h0100E000, 4'b1111, 32'hDEADBEEF, 2, 3, 0, 0, 32'h0,        ST_OK,    32'h0,         1,  3,  0,  0);
      run_cmd("rd",     1'b1, 32'h0100E004, 4'b1111, 32'hA5A5A5A5, 0, 1, 0, 0, 32'h12345678, ST_OK,    32'h12345678,  1,  1,  3,  0);
      run_cmd("retry2", 1'b0, 32'h0100E008, 4'b1100, 32'h0BADF00D, 1, 2, 2, 0, 32'h0,        ST_OK,    32'h0,         3,  2,  0,  0);
      run_cmd("retry4", 1'b1, 32'h0100E00C, 4'b0011, 32'h0,        0, 1, 4, 0, 32'hFFFF0000, ST_RETRY, 32'h0,         4,  1,  0,  0);
      run_cmd("errack", 1'b1, 32'h80000010, 4'b1111, 32'h0,        0, 2, 0, 1, 32'hCAFEF00D, ST_ERR,   32'h0,         1,  2,  0,  0);
      run_cmd("wdog",   1'b1, 32'h00000020, 4'b0001, 32'h0,        1, 0, 0, 2, 32'h0,        ST_TOUT,  32'h0,         1,  64, 0,  0);
      run_cmd("tmo",    1'b0, 32'h00000024, 4'b1000, 32'h00000012, 0, 5, 0, 3, 32'h0,        ST_TOUT,  32'h0,         1,  5,  0,  0);
      run_cmd("hold",   1'b0, 32'h0000FF00, 4'b1111, 32'h01020304, 0, 1, 0, 0, 32'h0,        ST_OK,    32'h0,         1,  1,  0,  10);
      run_cmd("after",  1'b1, 32'h76543210, 4'b0110, 32'h0,        0, 1, 0, 0, 32'h89ABCDEF, ST_OK,    32'h89ABCDEF,  1,  1,  3,  0);

      // reset in the middle of a selected write: no response may follow
      cmd_valid = 1'b1;
      cmd_rnw   = 1'b0;
      cmd_addr  = 32'h13579BDF;
      cmd_be    = 4'b1111;
      cmd_wdata = 32'h2468ACE0;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && !got_sel; i++) begin
         quiet_bus();
         OPB_MGrant = M_request;
         if (M_select) got_sel = 1'b1;
         else @(negedge clk);
      end
      chk("rst reached xfer", got_sel, 1'b1);
      quiet_bus();
      OPB_Rst_n = 1'b0;
      @(negedge clk);
      chk("rst ctrl", {M_request, M_select, M_RNW, M_BE, rsp_valid, cmd_ready}, 9'h0);
      chk("rst abus", M_ABus, 32'h0);
      chk("rst dbus", M_DBus, 32'h0);
      OPB_Rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         OPB_MGrant  = M_request;
         OPB_xferAck = M_select;
         if (rsp_valid || M_request || M_select) late_rsp = 1'b1;
      end
      quiet_bus();
      chk("rst no rsp", late_rsp, 1'b0);
      chk("rst ready", cmd_ready, 1'b1);

      run_cmd("post rst", 1'b1, 32'h00000040, 4'b1010, 32'h0, 0, 1, 0, 0, 32'h0F0F0F0F,
              ST_OK, 32'h0F0F0F0F, 1, 1, 3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
